// File: rtl/light_phase_sequencer_if.sv
// Bundle of the pattern/time inputs and the light outputs of the phase sequencer.
// The master side is the upstream mode generator plus the light observer; the slave
// side is the sequencer itself.
interface light_phase_sequencer_if;
    logic       tick;
    logic [7:0] nextLights;
    logic [6:0] loadTime;
    logic [7:0] lightOutput;
    logic       advance;
    logic [1:0] phase;
    logic [6:0] remaining;

    modport master (
        output tick, nextLights, loadTime,
        input  lightOutput, advance, phase, remaining
    );

    modport slave (
        input  tick, nextLights, loadTime,
        output lightOutput, advance, phase, remaining
    );
endinterface

// File: rtl/light_phase_sequencer.sv
// Light phase sequencer: walks the lights GREEN -> YELLOW -> ALL_RED with
// per-phase countdowns that only move on the 1 Hz tick enable.
module light_phase_sequencer #(
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    light_phase_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ALL_RED = 2'b00,
        GREEN   = 2'b01,
        YELLOW  = 2'b10
    } phase_t;

    localparam logic [6:0] YELLOW_TICKS  = 7'(YELLOW_TIME);
    localparam logic [6:0] ALL_RED_TICKS = 7'(ALL_RED_TIME);

    phase_t     state, state_next;
    logic [7:0] lights, lights_next;
    logic [6:0] remaining, remaining_next;
    logic       advance, advance_next;

    logic [7:0] norm_lights;
    logic [7:0] yellow_lights;
    logic [6:0] hold_time;
    logic       expire;

    // Normalise the candidate: any nonzero field means go (11).
    always_comb begin
        norm_lights = 8'h00;
        for (int i = 0; i < 4; i++) begin
            norm_lights[2*i +: 2] = (|bus.nextLights[2*i +: 2]) ? 2'b11 : 2'b00;
        end
    end

    // Every green field (11) turns yellow (01); red fields stay red.
    assign yellow_lights = lights & 8'h55;
    // A zero hold time still gives one tick of green.
    assign hold_time     = (bus.loadTime == 7'd0) ? 7'd1 : bus.loadTime;
    // remaining <= 1 is treated as expiry so a corrupted zero can never wrap.
    assign expire        = bus.tick && (remaining <= 7'd1);

    // Next phase, lights, countdown and advance pulse.
    always_comb begin
        state_next     = state;
        lights_next    = lights;
        remaining_next = remaining;
        advance_next   = 1'b0;
        if (expire) begin
            case (state)
                ALL_RED: begin
                    state_next     = GREEN;
                    lights_next    = norm_lights;
                    remaining_next = hold_time;
                    advance_next   = 1'b1;
                end
                GREEN: begin
                    if (norm_lights == lights) begin
                        // Same pattern requested again: extend without a yellow flash.
                        remaining_next = hold_time;
                        advance_next   = 1'b1;
                    end else begin
                        state_next     = YELLOW;
                        lights_next    = yellow_lights;
                        remaining_next = YELLOW_TICKS;
                    end
                end
                default: begin
                    // YELLOW expiry, and recovery from the unused encoding.
                    state_next     = ALL_RED;
                    lights_next    = 8'h00;
                    remaining_next = ALL_RED_TICKS;
                end
            endcase
        end else if (bus.tick) begin
            remaining_next = remaining - 7'd1;
        end
    end

    // State register; reset drops every light to red immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ALL_RED;
            lights    <= 8'h00;
            remaining <= ALL_RED_TICKS;
            advance   <= 1'b0;
        end else begin
            state     <= state_next;
            lights    <= lights_next;
            remaining <= remaining_next;
            advance   <= advance_next;
        end
    end

    assign bus.lightOutput = lights;
    assign bus.advance     = advance;
    assign bus.phase       = state;
    assign bus.remaining   = remaining;
endmodule

// File: tb/tb_light_phase_sequencer.sv
// Randomised bench for light_phase_sequencer against a tick-level behavioural model.
module tb_light_phase_sequencer;
    localparam int YT = 3;
    localparam int AR = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    light_phase_sequencer_if bus ();

    light_phase_sequencer #(.YELLOW_TIME(YT), .ALL_RED_TIME(AR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0=all red, 1=green, 2=yellow.
    int         m_ph;
    logic [7:0] m_lt;
    int         m_rem;
    bit         m_adv;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] norm(input logic [7:0] p);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 4; i++) if (p[2*i +: 2] != 2'b00) r[2*i +: 2] = 2'b11;
        return r;
    endfunction

    function automatic logic [7:0] to_yellow(input logic [7:0] p);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 4; i++) if (p[2*i +: 2] == 2'b11) r[2*i +: 2] = 2'b01;
        return r;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_lt = 8'h00; m_rem = AR; m_adv = 0;
    endtask

    task automatic model_edge(input bit tk, input logic [7:0] nl, input int lt);
        int hold = (lt < 1) ? 1 : lt;
        m_adv = 0;
        if (!tk) return;
        if (m_rem > 1) begin
            m_rem = m_rem - 1;
            return;
        end
        if (m_ph == 0) begin
            m_ph = 1; m_lt = norm(nl); m_rem = hold; m_adv = 1;
        end else if (m_ph == 1) begin
            if (norm(nl) == m_lt) begin
                m_rem = hold; m_adv = 1;
            end else begin
                m_ph = 2; m_lt = to_yellow(m_lt); m_rem = YT;
            end
        end else begin
            m_ph = 0; m_lt = 8'h00; m_rem = AR;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".lights"}, bus.lightOutput, m_lt);
        chk({tag, ".phase"},  bus.phase,       m_ph);
        chk({tag, ".remain"}, bus.remaining,   m_rem);
        chk({tag, ".adv"},    bus.advance,     m_adv);
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input string tag, input bit tk, input logic [7:0] nl, input int lt);
        bus.tick = tk; bus.nextLights = nl; bus.loadTime = 7'(lt);
        @(posedge clk);
        model_edge(tk, nl, lt);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] alt;
        int         adv_cnt;
        int         guard;
        bus.tick = 1'b0; bus.nextLights = 8'h00; bus.loadTime = 7'd0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        model_reset();
        check_all("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Basic cycle: 33 for 5 ticks, tick every 4 clocks
        for (int i = 0; i < 4 * 14; i++) step("basic", (i % 4) == 0, 8'h33 ^ ((i >= 28) ? 8'hFF : 8'h00), 5);

        // Mid-green asynchronous reset, away from the clock edge
        guard = 0;
        while (m_ph != 1 && guard < 200) begin
            step("to_green", 1'b1, 8'h33, 6); guard++;
        end
        chk("reach_green", m_ph, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.lights", bus.lightOutput, 8'h00);
        chk("async_rst.phase",  bus.phase,       0);
        #1 rst = 1'b0;
        step("post_rst", 1'b1, 8'hCC, 2);
        chk("post_rst.green", bus.phase, 1);

        // Alternation: upstream swaps pattern after each consumed sample
        alt = 8'h33; adv_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step("alt", 1'b1, alt, 2);
            if (m_adv) begin alt = (alt == 8'hCC) ? 8'h33 : 8'hCC; adv_cnt++; end
        end
        chk("alt.adv_count", (adv_cnt > 5) ? 1 : 0, 1);

        // Extension: pattern held, green never leaves
        for (int i = 0; i < 40; i++) step("ext", 1'b1, 8'hCC, 3);
        chk("ext.phase_green", bus.phase, 1);
        chk("ext.lights_cc", bus.lightOutput, 8'hCC);

        // Edges: loadTime 0, odd pattern 12, loadTime 127
        for (int i = 0; i < 20; i++) step("lt0", 1'b1, 8'h12, 0);
        for (int i = 0; i < 12; i++) step("lt127", 1'b1, 8'h81, 127);

        // tick gating with nextLights wiggling
        for (int i = 0; i < 1000; i++) step("gate", 1'b0, 8'($urandom), $urandom_range(0, 127));

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] nl;
            int lt;
            case ($urandom_range(0, 4))
                0: nl = 8'h33;
                1: nl = 8'hCC;
                2: nl = 8'h00;
                default: nl = 8'($urandom);
            endcase
            lt = ($urandom_range(0, 30) == 0) ? 127 : int'($urandom_range(0, 6));
            step("rand", $urandom_range(0, 2) == 0, nl, lt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
